multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
Multi-cycle control FSM for the RISC-V core. It sequences instruction fetch, decode, execute, memory access and write-back over a single shared memory port. It issues per-state strobes for the PC, IR, register file and memory, and resolves branches from the comparator flags BrEq/BrLT. It sits beside the combinational decoder, which still supplies ImmSel, ASel, BSel and ALUSel. This block owns only the timing and enable of state-changing operations.

Parameters:
MEM_WAIT_MAX, 15, max consecutive cycles waiting for mem_ready in FETCH/MEM before bus-error halt; 0 disables the timeout
WAIT_W, $clog2(MEM_WAIT_MAX+1) (min 1), width of the wait counter

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  reset, synchronous, active-low
opcode  in  7  IR[6:0]
funct3  in  3  IR[14:12]
BrEq  in  1  branch comparator equal flag
BrLT  in  1  branch comparator less-than flag
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request valid
mem_we  out  1  1 = write (sw), 0 = read
BrUn  out  1  unsigned compare select to comparator
ir_we  out  1  latch instruction from memory into IR
pc_we  out  1  update PC at next edge
PCSel  out  1  0 = PC+4, 1 = ALU result
RegWEn  out  1  register file write enable
state  out  3  current state encoding
illegal  out  1  sticky illegal-instruction flag
bus_err  out  1  sticky memory-timeout flag
retire  out  1  one-cycle pulse per completed instruction
instret  out  32  retired-instruction count (optional feature)

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6/7 go to HALT.
- Reset (rst_n low at edge): state=FETCH, wait counter=0, illegal=0, bus_err=0, instret=0.
- While rst_n is low, all strobe outputs are forced to 0 combinationally.
- Outputs are Moore/Mealy combinational from state and inputs. Every strobe not listed for a state is 0.
- FETCH: mem_req=1, mem_we=0.
  - mem_ready=1 → ir_we=1, go to DECODE.
  - Otherwise wait counter++ and stay.
- DECODE: one cycle, legality check.
  - Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 lw, 0100011 sw, 1100011 branch, 1101111 jal, 1100111 jalr, 0010111 auipc, 0110111 lui, 0000000 nop.
  - nop: pc_we=1, PCSel=0, retire=1, go to FETCH.
  - Any other opcode, or branch funct3 of 010/011: set illegal, go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - R/I-ALU/auipc/lui/jal/jalr → WB.
  - lw/sw → MEM.
  - Branch: BrUn=funct3[1]. taken = BrEq for 000, !BrEq for 001, BrLT for 100/110, !BrLT for 101/111. Outputs pc_we=1, PCSel=taken, retire=1, go to FETCH.
- MEM: mem_req=1, mem_we=(opcode==sw).
  - On mem_ready, sw: pc_we=1, PCSel=0, retire=1, go to FETCH.
  - On mem_ready, lw: go to WB.
- WB: RegWEn=1, pc_we=1, PCSel=(jal|jalr), retire=1, go to FETCH.
- HALT: all strobes 0. Absorbing until reset; illegal/bus_err hold.
- Wait counter:
  - Clears on every state transition.
  - In FETCH/MEM with mem_ready=0 and counter==MEM_WAIT_MAX (MEM_WAIT_MAX≠0): set bus_err, go to HALT next edge.
  - mem_ready=1 in the same cycle as the limit: ready wins, normal transition.
- mem_ready outside FETCH/MEM is ignored.
- Latency with zero-wait memory:
  - nop 2 cycles
  - branch 3
  - ALU/auipc/lui/jal/jalr/sw 4
  - lw 5
- Reset asserted mid-MEM: mem_req drops immediately; the next state is FETCH with no write-back and no retire.

Optional Feature:
SEQ_INSTRET_EN
- Defined: instret is a 32-bit counter, +1 on every retire pulse, wraps 0xFFFFFFFF→0, cleared by reset.
- Undefined: no counter logic; instret is tied to 0.

Test Plan:
- add (opcode 0110011), mem_ready=1 always → states 0,1,2,4; RegWEn=1 and retire=1 only in cycle 4; pc_we=1 with PCSel=0.
- lw with mem_ready low 3 cycles in MEM → mem_req=1, mem_we=0 for 4 MEM cycles; RegWEn in the following WB; total 8 cycles; bus_err=0.
- beq with BrEq=1, then bne with BrEq=1 → first: pc_we=1, PCSel=1; second: PCSel=0; each 3 cycles; BrUn=0. bltu with BrLT=1 → BrUn=1, PCSel=1.
- opcode 1111111 → illegal=1 after DECODE, state=5, no strobes for 10 further cycles; rst_n low one edge → state=0, illegal=0.
- FETCH with mem_ready held 0, MEM_WAIT_MAX=15 → HALT after 16 FETCH cycles, bus_err=1. Repeat with mem_ready=1 on the 16th cycle → DECODE, bus_err=0.
- SEQ_INSTRET_EN defined, 5 nops plus 1 sw → instret=6. Preload via force to 0xFFFFFFFF, one retire → 0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle control FSM for the RISC-V core.
// It steps each instruction through FETCH, DECODE, EXEC, MEM and WB over one
// shared memory port. It drives the PC/IR/register-file/memory strobes and
// resolves branches from the BrEq/BrLT flags.
// Optional feature: define SEQ_INSTRET_EN to build the 32-bit retired-instruction
// counter on `instret`. Without the macro, `instret` is tied to zero.
module multicycle_sequencer #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_W       = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        BrEq,
    input  logic        BrLT,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        BrUn,
    output logic        ir_we,
    output logic        pc_we,
    output logic        PCSel,
    output logic        RegWEn,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        bus_err,
    output logic        retire,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_NOP   = 7'b0000000;

    // Opcode legality; branches with funct3 010/011 have no defined compare.
    function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
        logic ok;
        case (op)
            OP_R, OP_IALU, OP_LW, OP_SW, OP_JAL,
            OP_JALR, OP_AUIPC, OP_LUI, OP_NOP: ok = 1'b1;
            OP_BR:   ok = (f3 != 3'b010) && (f3 != 3'b011);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Branch outcome from the comparator flags, selected by funct3.
    function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
        logic tk;
        case (f3)
            3'b000:          tk = eq;
            3'b001:          tk = ~eq;
            3'b100, 3'b110:  tk = lt;
            3'b101, 3'b111:  tk = ~lt;
            default:         tk = 1'b0;
        endcase
        return tk;
    endfunction

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                illegal_q, illegal_d;
    logic                bus_err_q, bus_err_d;

    logic mem_req_s, mem_we_s, br_un_s, ir_we_s, pc_we_s, pc_sel_s, reg_wen_s, retire_s;
    logic timeout_hit_s;

    // The wait limit only applies when a nonzero MEM_WAIT_MAX is configured.
    assign timeout_hit_s = (MEM_WAIT_MAX != 0) && (wait_q == WAIT_W'(MEM_WAIT_MAX));

    // Next-state, sticky-flag and strobe decode for the current state.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
        br_un_s   = 1'b0;
        ir_we_s   = 1'b0;
        pc_we_s   = 1'b0;
        pc_sel_s  = 1'b0;
        reg_wen_s = 1'b0;
        retire_s  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_we_s = 1'b1;
                    state_d = ST_DECODE;
                end else if (timeout_hit_s) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end else if (wait_q != WAIT_W'(MEM_WAIT_MAX)) begin
                    wait_d = wait_q + WAIT_W'(1);
                end else begin
                    wait_d = wait_q;
                end
            end
            ST_DECODE: begin
                if (!is_legal(opcode, funct3)) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else if (opcode == OP_NOP) begin
                    pc_we_s  = 1'b1;
                    retire_s = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (opcode)
                    OP_R, OP_IALU, OP_AUIPC, OP_LUI, OP_JAL, OP_JALR: state_d = ST_WB;
                    OP_LW, OP_SW: state_d = ST_MEM;
                    OP_BR: begin
                        br_un_s  = funct3[1];
                        pc_we_s  = 1'b1;
                        pc_sel_s = branch_taken(funct3, BrEq, BrLT);
                        retire_s = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    default: begin
                        // IR changed under us after DECODE: stop rather than guess.
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req_s = 1'b1;
                mem_we_s  = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_SW) begin
                        pc_we_s  = 1'b1;
                        retire_s = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout_hit_s) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_HALT;
                end else if (wait_q != WAIT_W'(MEM_WAIT_MAX)) begin
                    wait_d = wait_q + WAIT_W'(1);
                end else begin
                    wait_d = wait_q;
                end
            end
            ST_WB: begin
                reg_wen_s = 1'b1;
                pc_we_s   = 1'b1;
                pc_sel_s  = (opcode == OP_JAL) || (opcode == OP_JALR);
                retire_s  = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HALT;
        endcase
        if (state_d != state_q) begin
            wait_d = '0;
        end else begin
            wait_d = wait_d;
        end
    end

    // State, wait counter and sticky error flags with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Strobes are silenced the moment reset is asserted, even mid-transaction.
    assign mem_req = rst_n & mem_req_s;
    assign mem_we  = rst_n & mem_we_s;
    assign BrUn    = rst_n & br_un_s;
    assign ir_we   = rst_n & ir_we_s;
    assign pc_we   = rst_n & pc_we_s;
    assign PCSel   = rst_n & pc_sel_s;
    assign RegWEn  = rst_n & reg_wen_s;
    assign retire  = rst_n & retire_s;
    assign state   = state_q;
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;

`ifdef SEQ_INSTRET_EN
    logic [31:0] instret_q, instret_d;

    // Retired-instruction count; wraps naturally at 32 bits.
    always_comb begin
        instret_d = instret_q + {31'd0, retire};
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instret_q <= 32'd0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: latency table, directed
// corner sequences and randomized instructions against a trace model.
module tb_multicycle_sequencer;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_NOP   = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst_n, BrEq, BrLT, mem_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        mem_req, mem_we, BrUn, ir_we, pc_we, PCSel, RegWEn, illegal, bus_err, retire;
    logic [2:0]  state;
    logic [31:0] instret;

    logic [6:0]  cur_op;
    logic [2:0]  cur_f3;
    logic        cur_eq, cur_lt;

    int n_cmp  = 0;
    int n_fail = 0;

    multicycle_sequencer #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .BrEq(BrEq), .BrLT(BrLT), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .BrUn(BrUn), .ir_we(ir_we),
        .pc_we(pc_we), .PCSel(PCSel), .RegWEn(RegWEn), .state(state),
        .illegal(illegal), .bus_err(bus_err), .retire(retire), .instret(instret)
    );

    always #5 clk = ~clk;

    // {state, mem_req, mem_we, ir_we, pc_we, PCSel, RegWEn, retire, BrUn}
    logic [10:0] obs;
    assign obs = {state, mem_req, mem_we, ir_we, pc_we, PCSel, RegWEn, retire, BrUn};

    typedef struct packed {
        logic        rdy;
        logic [10:0] exp;
    } cyc_t;
    cyc_t trace[$];

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic       eq;
        logic       lt;
        int         cycles;
        logic       pcsel;
        logic       regwen;
        logic       brun;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs on the falling edge, then sample one step later.
    task automatic step(input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        opcode    = cur_op;
        funct3    = cur_f3;
        BrEq      = cur_eq;
        BrLT      = cur_lt;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0);
        step(1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic eq, input logic lt);
        cur_op = op;
        cur_f3 = f3;
        cur_eq = eq;
        cur_lt = lt;
    endtask

    function automatic logic taken_of(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'b000:         return eq;
            3'b001:         return !eq;
            3'b100, 3'b110: return lt;
            3'b101, 3'b111: return !lt;
            default:        return 1'b0;
        endcase
    endfunction

    // strobes = {mem_req, mem_we, ir_we, pc_we, PCSel, RegWEn, retire, BrUn}
    function automatic void push(input logic [2:0] st, input logic [7:0] strobes, input logic rdy);
        cyc_t c;
        c.rdy = rdy;
        c.exp = {st, strobes};
        trace.push_back(c);
    endfunction

    // Expected cycle-by-cycle behaviour of one instruction with given memory waits.
    function automatic void build(input logic [6:0] op, input logic [2:0] f3, input logic eq,
                                  input logic lt, input int fw, input int mw);
        logic is_sw;
        logic tk;
        is_sw = (op == OP_SW);
        trace.delete();
        for (int i = 0; i <= fw; i++)
            push(3'd0, {1'b1, 1'b0, (i == fw), 5'b00000}, (i == fw));
        if (op == OP_NOP) begin
            push(3'd1, 8'b0001_0010, 1'($urandom_range(0, 1)));
            return;
        end
        push(3'd1, 8'b0, 1'($urandom_range(0, 1)));
        if (op == OP_BR) begin
            tk = taken_of(f3, eq, lt);
            push(3'd2, {3'b000, 1'b1, tk, 1'b0, 1'b1, f3[1]}, 1'($urandom_range(0, 1)));
            return;
        end
        push(3'd2, 8'b0, 1'($urandom_range(0, 1)));
        if (op == OP_LW || is_sw) begin
            for (int i = 0; i <= mw; i++)
                push(3'd3, {1'b1, is_sw, 1'b0, (i == mw) && is_sw, 2'b00, (i == mw) && is_sw, 1'b0},
                     (i == mw));
            if (is_sw) return;
        end
        push(3'd4, {3'b000, 1'b1, (op == OP_JAL) || (op == OP_JALR), 1'b1, 1'b1, 1'b0},
             1'($urandom_range(0, 1)));
    endfunction

    task automatic run_trace(input string name);
        foreach (trace[i]) begin
            step(trace[i].rdy);
            check(name, {53'd0, obs}, {53'd0, trace[i].exp});
        end
    endtask

    vec_t vt[14];
    logic [6:0] legal_ops[10];

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b0;
        set_instr(OP_R, 3'b000, 1'b0, 1'b0);

        vt[0]  = '{"add",   OP_R,     3'b000, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0};
        vt[1]  = '{"addi",  OP_IALU,  3'b000, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{"lw",    OP_LW,    3'b010, 1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{"sw",    OP_SW,    3'b010, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{"beq_t", OP_BR,    3'b000, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{"bne_n", OP_BR,    3'b001, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{"bltu",  OP_BR,    3'b110, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{"bge_n", OP_BR,    3'b101, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{"blt_t", OP_BR,    3'b100, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{"jal",   OP_JAL,   3'b000, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0};
        vt[10] = '{"jalr",  OP_JALR,  3'b000, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0};
        vt[11] = '{"auipc", OP_AUIPC, 3'b000, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0};
        vt[12] = '{"lui",   OP_LUI,   3'b000, 1'b0, 1'b0, 4, 1'b0, 1'b1, 1'b0};
        vt[13] = '{"nop",   OP_NOP,   3'b000, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};

        legal_ops = '{OP_R, OP_IALU, OP_LW, OP_SW, OP_BR, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI, OP_NOP};

        // Reset state: strobes gated while rst_n is low.
        step(1'b1);
        check("rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("rst_ir_we",   {63'd0, ir_we},   64'd0);
        check("rst_state",   {61'd0, state},   64'd0);
        check("rst_illegal", {63'd0, illegal}, 64'd0);
        check("rst_bus_err", {63'd0, bus_err}, 64'd0);
        check("rst_instret", {32'd0, instret}, 64'd0);
        do_reset();

        // Latency table with zero-wait memory.
        for (int v = 0; v < 14; v++) begin
            int  cyc;
            logic done;
            set_instr(vt[v].op, vt[v].f3, vt[v].eq, vt[v].lt);
            cyc  = 0;
            done = 1'b0;
            while (!done && cyc < 20) begin
                step(1'b1);
                cyc++;
                if (retire === 1'b1) begin
                    done = 1'b1;
                    check({vt[v].name, "_pc_we"},  {63'd0, pc_we},  64'd1);
                    check({vt[v].name, "_pcsel"},  {63'd0, PCSel},  {63'd0, vt[v].pcsel});
                    check({vt[v].name, "_regwen"}, {63'd0, RegWEn}, {63'd0, vt[v].regwen});
                    check({vt[v].name, "_brun"},   {63'd0, BrUn},   {63'd0, vt[v].brun});
                end
            end
            check({vt[v].name, "_cycles"}, 64'(cyc), 64'(vt[v].cycles));
        end

        // lw with three wait cycles in MEM: 8 cycles total.
        set_instr(OP_LW, 3'b010, 1'b0, 1'b0);
        build(OP_LW, 3'b010, 1'b0, 1'b0, 0, 3);
        run_trace("lw_wait3");
        step(1'b0);
        check("lw_wait3_bus_err", {63'd0, bus_err}, 64'd0);
        check("lw_wait3_back_fetch", {61'd0, state}, 64'd0);

        // Randomized instructions and memory waits against the trace model.
        do_reset();
        for (int n = 0; n < 150; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic eq, lt;
            int fw, mw;
            op = legal_ops[$urandom_range(0, 9)];
            f3 = 3'($urandom_range(0, 7));
            if (op == OP_BR && (f3 == 3'b010 || f3 == 3'b011)) f3 = 3'b000;
            eq = 1'($urandom_range(0, 1));
            lt = 1'($urandom_range(0, 1));
            fw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            mw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            set_instr(op, f3, eq, lt);
            build(op, f3, eq, lt, fw, mw);
            run_trace("rand");
        end
        step(1'b0);
        check("rand_illegal", {63'd0, illegal}, 64'd0);
        check("rand_bus_err", {63'd0, bus_err}, 64'd0);

        // Illegal opcode: HALT is absorbing, then reset clears it.
        do_reset();
        set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
        step(1'b1);
        step(1'b1);
        check("ill_decode", {53'd0, obs}, {53'd0, 3'd1, 8'd0});
        step(1'b1);
        check("ill_state", {61'd0, state}, 64'd5);
        check("ill_flag", {63'd0, illegal}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom_range(0, 1)));
            check("ill_halt_quiet", {53'd0, obs}, {53'd0, 3'd5, 8'd0});
        end
        check("ill_sticky", {63'd0, illegal}, 64'd1);
        set_instr(OP_R, 3'b000, 1'b0, 1'b0);
        rst_n = 1'b0;
        step(1'b0);
        check("ill_rst_state", {61'd0, state}, 64'd0);
        check("ill_rst_flag", {63'd0, illegal}, 64'd0);
        rst_n = 1'b1;

        // Branch with an undefined funct3 is illegal.
        do_reset();
        set_instr(OP_BR, 3'b010, 1'b0, 1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        check("br010_state", {61'd0, state}, 64'd5);
        check("br010_illegal", {63'd0, illegal}, 64'd1);

        // FETCH timeout after 16 waiting cycles.
        do_reset();
        set_instr(OP_R, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0);
            check("to_fetch_wait", {53'd0, obs}, {53'd0, 3'd0, 8'b1000_0000});
        end
        step(1'b0);
        check("to_halt_state", {61'd0, state}, 64'd5);
        check("to_bus_err", {63'd0, bus_err}, 64'd1);
        check("to_halt_quiet", {63'd0, mem_req}, 64'd0);

        // Ready on the limit cycle wins over the timeout.
        do_reset();
        for (int i = 0; i < 15; i++) step(1'b0);
        step(1'b1);
        check("to_ready_irwe", {63'd0, ir_we}, 64'd1);
        step(1'b0);
        check("to_ready_decode", {61'd0, state}, 64'd1);
        check("to_ready_bus_err", {63'd0, bus_err}, 64'd0);

        // Reset asserted mid-MEM: strobes drop at once, next state FETCH.
        do_reset();
        set_instr(OP_SW, 3'b010, 1'b0, 1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        check("mid_mem_req", {53'd0, obs}, {53'd0, 3'd3, 8'b1100_0000});
        rst_n = 1'b0;
        #1;
        check("mid_rst_strobes", {56'd0, obs[7:0]}, 64'd0);
        step(1'b1);
        check("mid_rst_state", {61'd0, state}, 64'd0);
        rst_n = 1'b1;

`ifdef SEQ_INSTRET_EN
        // Retire counter: 5 nops plus one sw, then wrap from all-ones.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_instr(OP_NOP, 3'b000, 1'b0, 1'b0);
            build(OP_NOP, 3'b000, 1'b0, 1'b0, 0, 0);
            run_trace("cnt_nop");
        end
        set_instr(OP_SW, 3'b010, 1'b0, 1'b0);
        build(OP_SW, 3'b010, 1'b0, 1'b0, 0, 0);
        run_trace("cnt_sw");
        step(1'b0);
        check("instret_six", {32'd0, instret}, 64'd6);
        set_instr(OP_NOP, 3'b000, 1'b0, 1'b0);
        force dut.instret_q = 32'hFFFF_FFFF;
        step(1'b1);
        release dut.instret_q;
        step(1'b0);
        step(1'b0);
        check("instret_wrap", {32'd0, instret}, 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
